// File: rtl/addsub_serial_ctrl.sv
// Nibble-serial two's-complement adder/subtractor.
// One 4-bit slice is processed per clock, LSB slice first, and the carry is kept between slices.

module addsub_serial_ctrl_slice4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       c3_o,
  output logic       cout_o
);
  logic [3:0] lo;
  logic [1:0] hi;

  // The carry into bit 3 is exposed separately because the signed-overflow flag needs it.
  always_comb begin
    lo     = {1'b0, a_i[2:0]} + {1'b0, b_i[2:0]} + {3'b000, cin_i};
    hi     = {1'b0, a_i[3]} + {1'b0, b_i[3]} + {1'b0, lo[3]};
    sum_o  = {hi[0], lo[2:0]};
    c3_o   = lo[3];
    cout_o = hi[1];
  end
endmodule

module addsub_serial_ctrl #(
  parameter int unsigned N_NIB = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*N_NIB-1:0]   a,
  input  logic [4*N_NIB-1:0]   b,
  input  logic                 sub,
  output logic                 busy,
  output logic                 done,
  output logic [4*N_NIB-1:0]   result,
  output logic                 ovfl,
  output logic                 carry_out
);
  localparam int unsigned W  = 4 * N_NIB;
  localparam int unsigned CW = (N_NIB > 1) ? $clog2(N_NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           carry_q, carry_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic           sub_q, sub_d;
  logic [W-1:0]   result_q, result_d;
  logic           ovfl_q, ovfl_d;
  logic           cout_q, cout_d;

  logic [3:0]     slice_a, slice_b, slice_sum;
  logic           slice_c3, slice_cout;
  logic           accept, last;

  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int unsigned i = 0; i < N_NIB; i++) begin
      if (cnt_q == CW'(i)) begin
        slice_a = a_q[4*i +: 4];
        slice_b = b_q[4*i +: 4] ^ {4{sub_q}};
      end
    end
  end

  addsub_serial_ctrl_slice4 u_slice (
    .a_i    (slice_a),
    .b_i    (slice_b),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .c3_o   (slice_c3),
    .cout_o (slice_cout)
  );

  assign accept = start && (state_q != RUN);
  assign last   = (cnt_q == CW'(N_NIB - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    result_d = result_q;
    ovfl_d   = ovfl_q;
    cout_d   = cout_q;

    if (accept) begin
      state_d = RUN;
      a_d     = a;
      b_d     = b;
      sub_d   = sub;
      cnt_d   = '0;
      carry_d = sub;
    end else begin
      case (state_q)
        RUN: begin
          for (int unsigned i = 0; i < N_NIB; i++) begin
            if (cnt_q == CW'(i)) result_d[4*i +: 4] = slice_sum;
          end
          carry_d = slice_cout;
          cnt_d   = cnt_q + CW'(1);
          if (last) begin
            state_d = DONE;
            cout_d  = slice_cout;
            ovfl_d  = slice_c3 ^ slice_cout;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      result_q <= '0;
      ovfl_q   <= 1'b0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      result_q <= result_d;
      ovfl_q   <= ovfl_d;
      cout_q   <= cout_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign ovfl      = ovfl_q;
  assign carry_out = cout_q;
endmodule

// File: tb/tb_addsub_serial_ctrl.sv
// Bench for addsub_serial_ctrl: directed corner cases plus random operations.
// Each result is compared against an integer-arithmetic reference model.

module tb_addsub_serial_ctrl;
  localparam int unsigned N_NIB = 4;
  localparam int unsigned W     = 4 * N_NIB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         busy, done, ovfl, carry_out;
  logic [W-1:0] result;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  addsub_serial_ctrl #(.N_NIB(N_NIB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .ovfl      (ovfl),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer arithmetic, then wrap and range-check.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts);
    longint sa, sb, sr;
    longint ua, ub;
    logic [W-1:0] r;
    logic c, o;
    sa = longint'($signed(ta));
    sb = longint'($signed(tb));
    ua = longint'(ta);
    ub = longint'(tb);
    sr = ts ? (sa - sb) : (sa + sb);
    r  = ts ? (ta - tb) : (ta + tb);
    c  = ts ? (ua >= ub) : ((ua + ub) >= (longint'(1) << W));
    o  = (sr > ((longint'(1) << (W-1)) - 1)) || (sr < -(longint'(1) << (W-1)));
    return {o, c, r};
  endfunction

  // Starts an operation from the current sample point (#1 after an edge, state IDLE or DONE).
  // inject: pulse junk starts during RUN. chain: leave the bench in the DONE cycle.
  task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic ts, input bit inject, input bit chain);
    logic [W+1:0] exp;
    int unsigned edges, busy_cnt;
    exp = ref_op(ta, tb, ts);
    start = 1'b1; a = ta; b = tb; sub = ts;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; sub = $urandom_range(0, 1);
    edges = 0; busy_cnt = 0;
    while (!done && edges < 20) begin
      if (busy) busy_cnt++;
      if (inject) begin
        start = $urandom_range(0, 1);
        a = '1; b = $urandom; sub = $urandom_range(0, 1);
      end
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0;
    check({tag, ".latency"}, 64'(edges), 64'(N_NIB));
    check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(N_NIB));
    check({tag, ".done"}, 64'(done), 64'd1);
    check({tag, ".busy_in_done"}, 64'(busy), 64'd0);
    check({tag, ".result"}, 64'(result), 64'(exp[W-1:0]));
    check({tag, ".carry_out"}, 64'(carry_out), 64'(exp[W]));
    check({tag, ".ovfl"}, 64'(ovfl), 64'(exp[W+1]));
    if (!chain) begin
      @(posedge clk); #1;
      check({tag, ".done_pulse"}, 64'(done), 64'd0);
      check({tag, ".idle_busy"}, 64'(busy), 64'd0);
      check({tag, ".hold_result"}, 64'({ovfl, carry_out, result}), 64'(exp));
    end
  endtask

  initial begin
    #3;
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    check("rst.outs", 64'({ovfl, carry_out, result}), 64'd0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("add_3_4",      16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0);
    do_op("add_ovf",      16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    do_op("sub_ovf",      16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0);
    do_op("sub_neg",      16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0);
    do_op("ign_start",    16'h1234, 16'h1111, 1'b0, 1'b1, 1'b0);
    do_op("b2b_first",    16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1);
    do_op("b2b_second",   16'h0010, 16'h0001, 1'b1, 1'b0, 1'b0);

    // Reset in the 2nd RUN cycle must clear outputs at once and suppress done.
    start = 1'b1; a = 16'h4321; b = 16'h1111; sub = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst.busy", 64'(busy), 64'd0);
    check("midrst.done", 64'(done), 64'd0);
    check("midrst.outs", 64'({ovfl, carry_out, result}), 64'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check("midrst.no_done", 64'(done), 64'd0);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    do_op("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if (i % 5 == 0) ra = '1;
      if (i % 7 == 0) rb = {1'b1, {(W-1){1'b0}}};
      do_op("rand", ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            (i != 39) && ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
